// File: rtl/fpu_poly_horner_seq.sv
// Horner-method polynomial sequencer for F2XM1 / LOG2: walks the coefficient ROM
// and drives a shared FP80 multiply/add unit through a req/ack handshake.
module fpu_poly_horner_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  poly_sel,
  input  logic [79:0] x_in,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [79:0] result,
  output logic [3:0]  rom_poly_select,
  output logic [3:0]  rom_coeff_index,
  input  logic [79:0] rom_coefficient,
  output logic        arith_req,
  output logic        arith_op,
  output logic [79:0] arith_a,
  output logic [79:0] arith_b,
  input  logic        arith_ack,
  input  logic [79:0] arith_result
);

  localparam logic [3:0] POLY_F2XM1 = 4'd0;
  localparam logic [3:0] POLY_LOG2  = 4'd1;
  localparam logic [3:0] LAST_F2XM1 = 4'd5;
  localparam logic [3:0] LAST_LOG2  = 4'd7;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_ADD, S_FMUL, S_FIN} state_e;

  state_e      state_q, state_d;
  logic [79:0] acc_q, acc_d;
  logic [79:0] x_q, x_d;
  logic [79:0] result_q, result_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        op_active;

  assign op_active = (state_q == S_MUL) || (state_q == S_ADD) || (state_q == S_FMUL);

  // NOTE: every always_comb target gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    x_d      = x_q;
    result_d = result_q;
    sel_d    = sel_q;
    idx_d    = idx_q;
    err_d    = err_q;

    // Abort wins over everything, including a start in IDLE and a same-cycle ack.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (poly_sel == POLY_F2XM1 || poly_sel == POLY_LOG2) begin
              x_d     = x_in;
              sel_d   = poly_sel;
              idx_d   = (poly_sel == POLY_LOG2) ? LAST_LOG2 : LAST_F2XM1;
              err_d   = 1'b0;
              state_d = S_LOAD;
            end else begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = S_FIN;
            end
          end
        end
        S_LOAD: begin
          acc_d   = rom_coefficient;
          idx_d   = idx_q - 4'd1;
          state_d = S_MUL;
        end
        S_MUL: begin
          if (arith_ack) begin
            acc_d   = arith_result;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          if (arith_ack) begin
            acc_d = arith_result;
            if (idx_q == 4'd0) begin
              state_d = S_FMUL;
            end else begin
              idx_d   = idx_q - 4'd1;
              state_d = S_MUL;
            end
          end
        end
        S_FMUL: begin
          if (arith_ack) begin
            result_d = arith_result;
            state_d  = S_FIN;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      x_q      <= '0;
      result_q <= '0;
      sel_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
    end
  end

  // Outputs decode straight from registered state, so an async reset clears them at once
  // and the operands stay put for the whole request (ACC, X and ROM address only move on ack).
  always_comb begin
    busy      = (state_q == S_LOAD) || op_active;
    done      = (state_q == S_FIN);
    error     = (state_q == S_FIN) && err_q;
    arith_req = op_active;
    arith_op  = (state_q == S_ADD);
    arith_a   = '0;
    arith_b   = '0;
    if (op_active) begin
      arith_a = acc_q;
      arith_b = (state_q == S_ADD) ? rom_coefficient : x_q;
    end
  end

  assign result          = result_q;
  assign rom_poly_select = sel_q;
  assign rom_coeff_index = idx_q;

endmodule

// File: tb/tb_fpu_poly_horner_seq.sv
// Directed bench for fpu_poly_horner_seq: bench-side coefficient ROM and an FP80
// mul/add responder with programmable ack wait, checked against hand-computed results.
module tb_fpu_poly_horner_seq;

  localparam logic [79:0] FP_ONE  = 80'h3FFF_8000000000000000;
  localparam logic [79:0] FP_TWO  = 80'h4000_8000000000000000;
  localparam logic [79:0] FP_5875 = 80'h4001_BC00000000000000; // 5.875
  localparam logic [79:0] FP_12   = 80'h4002_C000000000000000; // 12.0
  localparam logic [79:0] FP_1968 = 80'h3FFF_FC00000000000000; // 1.96875

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [3:0]  poly_sel;
  logic [79:0] x_in;
  logic        busy, done, error;
  logic [79:0] result;
  logic [3:0]  rom_poly_select, rom_coeff_index;
  logic [79:0] rom_coefficient;
  logic        arith_req, arith_op;
  logic [79:0] arith_a, arith_b;
  logic        arith_ack;
  logic [79:0] arith_result;

  fpu_poly_horner_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .poly_sel(poly_sel), .x_in(x_in), .busy(busy), .done(done), .error(error),
    .result(result), .rom_poly_select(rom_poly_select), .rom_coeff_index(rom_coeff_index),
    .rom_coefficient(rom_coefficient), .arith_req(arith_req), .arith_op(arith_op),
    .arith_a(arith_a), .arith_b(arith_b), .arith_ack(arith_ack), .arith_result(arith_result)
  );

  always #5 clk = ~clk;

  // FP80 <-> real for normal numbers; all coefficients and partial sums are exact dyadics.
  function automatic real fp2r(input logic [79:0] f);
    logic [63:0] d;
    if (f[78:0] == 79'd0) return 0.0;
    d = {f[79], 11'(int'(f[78:64]) - 16383 + 1023), f[62:11]};
    return $bitstoreal(d);
  endfunction

  function automatic logic [79:0] r2fp(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 80'h0;
    return {d[63], 15'(int'(d[62:52]) - 1023 + 16383), 1'b1, d[51:0], 11'h0};
  endfunction

  function automatic logic [79:0] rom(input logic [3:0] s, input logic [3:0] i);
    real v;
    v = 0.0;
    if (s == 4'd0) begin
      case (i)
        4'd0: v = 1.0;    4'd1: v = 0.5;    4'd2: v = 0.25;
        4'd3: v = 0.125;  4'd4: v = 0.0625; 4'd5: v = 0.03125;
        default: v = 0.0;
      endcase
    end else if (s == 4'd1) begin
      case (i)
        4'd0: v = 4.0;    4'd1: v = -1.5;   4'd2: v = 0.75;  4'd3: v = 2.0;
        4'd4: v = -0.125; 4'd5: v = 0.25;   4'd6: v = -0.5;  4'd7: v = 1.0;
        default: v = 0.0;
      endcase
    end
    return r2fp(v);
  endfunction

  assign rom_coefficient = rom(rom_poly_select, rom_coeff_index);

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc, ack_wait, abort_cyc, spur_cyc, wcnt;
  int          done_cyc, done_cnt, busy_bad, stable_bad, idle_bad;
  logic        req_seen, in_op, err_at_done, req_after, busy_after;
  logic [79:0] res_at_done, idx_pack, a_s, b_s;
  logic [3:0]  load_idx, idx_s;
  logic        op_s, exp_busy;
  string       ops;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One cycle: sample at the falling edge, then drive ack/abort/start for the next rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    exp_busy = (done_cyc < 0) && !done && !(abort_cyc > 0 && cyc > abort_cyc);
    if (busy !== exp_busy) busy_bad++;
    if (cyc == 1) load_idx = rom_coeff_index;
    if (abort_cyc > 0 && cyc == abort_cyc + 1) begin
      req_after  = arith_req;
      busy_after = busy;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) begin
        done_cyc    = cyc;
        res_at_done = result;
        err_at_done = error;
      end
    end
    arith_ack = 1'b0;
    if (arith_req) begin
      req_seen = 1'b1;
      if (!in_op) begin
        in_op = 1'b1; wcnt = 0;
        op_s = arith_op; a_s = arith_a; b_s = arith_b; idx_s = rom_coeff_index;
      end else if (op_s !== arith_op || a_s !== arith_a || b_s !== arith_b || idx_s !== rom_coeff_index) begin
        stable_bad++;
      end
      if (wcnt == ack_wait) begin
        arith_ack    = 1'b1;
        arith_result = arith_op ? r2fp(fp2r(arith_a) + fp2r(arith_b))
                                : r2fp(fp2r(arith_a) * fp2r(arith_b));
        ops = {ops, arith_op ? "A" : "M"};
        if (arith_op) idx_pack = {idx_pack[75:0], rom_coeff_index};
        in_op = 1'b0;
      end else begin
        wcnt++;
      end
    end else begin
      in_op = 1'b0;
    end
    abort = (abort_cyc > 0 && cyc == abort_cyc);
    start = (spur_cyc > 0 && cyc == spur_cyc);
    if (start) poly_sel = 4'd2;
  endtask

  task automatic clear_trace();
    ops = ""; idx_pack = '0; load_idx = '1; done_cyc = -1; done_cnt = 0;
    res_at_done = '0; err_at_done = 1'b0; req_seen = 1'b0; busy_bad = 0;
    stable_bad = 0; in_op = 1'b0; req_after = 1'b1; busy_after = 1'b1; cyc = 0;
  endtask

  task automatic run(input logic [3:0] sel, input logic [79:0] x, input int wt,
                     input int ab, input int sp, input int n);
    ack_wait = wt; abort_cyc = ab; spur_cyc = sp;
    clear_trace();
    poly_sel = sel; x_in = x; start = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; poly_sel = '0; x_in = '0;
    arith_ack = 1'b0; arith_result = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", arith_req, 0);
    check("rst_result", result, 0);
    check("rst_rom_addr", {rom_poly_select, rom_coeff_index}, 0);
    check("rst_arith_a", arith_a, 0);
    #2 reset_n = 1'b1;

    // F2XM1 at x = 0, zero-wait
    run(4'd0, 80'h0, 0, 0, 0, 20);
    check("t1_ops", 80'(ops == "MAMAMAMAMAM"), 1);
    check("t1_load_idx", 80'(load_idx), 5);
    check("t1_add_idx", idx_pack, 80'h43210);
    check("t1_done_cyc", 80'(done_cyc), 13);
    check("t1_result", res_at_done, 80'h0);
    check("t1_error", 80'(err_at_done), 0);
    check("t1_busy", 80'(busy_bad), 0);

    // LOG2 at x = 1.0: sum of coefficients = 5.875
    run(4'd1, FP_ONE, 0, 0, 0, 24);
    check("t2_nops", 80'(ops.len()), 15);
    check("t2_load_idx", 80'(load_idx), 7);
    check("t2_add_idx", idx_pack, 80'h6543210);
    check("t2_done_cyc", 80'(done_cyc), 17);
    check("t2_result", res_at_done, FP_5875);
    check("t2_busy", 80'(busy_bad), 0);

    // Abort in the third ADD (cycle 7) with ack high the same cycle
    run(4'd1, FP_ONE, 0, 7, 0, 20);
    check("t5_req_after", 80'(req_after), 0);
    check("t5_busy_after", 80'(busy_after), 0);
    check("t5_no_done", 80'(done_cnt), 0);
    check("t5_result_kept", result, FP_5875);

    // Normal F2XM1 at x = 2.0 with an invalid start pulsed mid-run
    run(4'd0, FP_TWO, 0, 0, 5, 20);
    check("t5b_done_cyc", 80'(done_cyc), 13);
    check("t5b_result", res_at_done, FP_12);
    check("t5b_error", 80'(err_at_done), 0);
    check("t5b_done_cnt", 80'(done_cnt), 1);

    // Invalid selector
    run(4'd2, FP_ONE, 0, 0, 0, 6);
    check("t4_req_seen", 80'(req_seen), 0);
    check("t4_done_cyc", 80'(done_cyc), 1);
    check("t4_error", 80'(err_at_done), 1);
    check("t4_result", res_at_done, 80'h0);
    check("t4_busy", 80'(busy_bad), 0);

    // F2XM1 at x = 1.0 with three wait cycles per op
    run(4'd0, FP_ONE, 3, 0, 0, 55);
    check("t3_ops", 80'(ops == "MAMAMAMAMAM"), 1);
    check("t3_stable", 80'(stable_bad), 0);
    check("t3_done_cyc", 80'(done_cyc), 46);
    check("t3_result", res_at_done, FP_1968);

    // Asynchronous reset between edges while in the first MUL
    ack_wait = 3; abort_cyc = 0; spur_cyc = 0;
    clear_trace();
    poly_sel = 4'd0; x_in = FP_TWO; start = 1'b1;
    step();
    step();
    check("t6_in_mul", 80'(arith_req), 1);
    #2 reset_n = 1'b0; arith_ack = 1'b0;
    #1;
    check("t6_req", 80'(arith_req), 0);
    check("t6_busy", 80'(busy), 0);
    check("t6_result", result, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (busy || arith_req || done) idle_bad++;
    end
    check("t6_idle", 80'(idle_bad), 0);
    run(4'd0, FP_TWO, 0, 0, 0, 20);
    check("t6_rerun_done", 80'(done_cyc), 13);
    check("t6_rerun_result", res_at_done, FP_12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
